// File: rtl/uart_wb_ctrl.sv
// Wishbone-attached 8N1 UART: 8-deep TX FIFO feeding a serial transmitter, and a
// receiver with a one-byte holding register plus sticky overrun/framing flags.
module uart_wb_ctrl #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_AW      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wishbone_cyc_i,
  input  logic        wishbone_stb_i,
  input  logic        wishbone_we_i,
  input  logic [31:0] wishbone_addr_i,
  input  logic [31:0] wishbone_data_i,
  input  logic [3:0]  wishbone_select_i,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_ack_o,
  input  logic        com_RxD,
  output logic        com_TxD,
  output logic [1:0]  tx_state_o,
  output logic [1:0]  rx_state_o
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [FIFO_AW:0]  wp_q, wp_d, rp_q, rp_d;
  logic [7:0]        mem_q [DEPTH];
  state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_sh_q, tx_sh_d;
  logic              txd_q, txd_d;
  logic              rx_s1_q, rx_s2_q;
  state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;

  logic req, wr_data, rd_data, rd_stat;
  logic empty, full, pop, push, tx_idle;
  logic unused_bits;

  assign unused_bits = ^{wishbone_addr_i[31:3], wishbone_addr_i[1:0],
                         wishbone_data_i[31:8], wishbone_select_i[3:1]};

  // The !ack term gives the mandatory low cycle between back-to-back acks.
  assign req     = wishbone_cyc_i & wishbone_stb_i & ~ack_q;
  assign wr_data = req & wishbone_we_i & ~wishbone_addr_i[2] & wishbone_select_i[0];
  assign rd_data = req & ~wishbone_we_i & ~wishbone_addr_i[2];
  assign rd_stat = req & ~wishbone_we_i & wishbone_addr_i[2];

  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) &&
                   (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
  assign pop     = (tx_state_q == S_IDLE) & ~empty;
  assign push    = wr_data & (~full | pop);
  assign tx_idle = empty & (tx_state_q == S_IDLE);

  assign wp_d = wp_q + (FIFO_AW + 1)'(push);
  assign rp_d = rp_q + (FIFO_AW + 1)'(pop);

  always_comb begin
    ack_d = req;
    dat_d = '0;
    if (rd_data)      dat_d = {24'b0, rx_data_q};
    else if (rd_stat) dat_d = {27'b0, rx_ferr_q, rx_ovr_q, rx_valid_q, tx_idle, full};
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    unique case (tx_state_q)
      S_IDLE: if (!empty) begin
        tx_sh_d    = mem_q[rp_q[FIFO_AW-1:0]];
        tx_cnt_d   = '0;
        tx_state_d = S_START;
      end
      S_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = S_DATA;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      S_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        tx_sh_d  = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 1'b1;
        if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      S_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_state_d = S_IDLE;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
    endcase
    // Line level is registered off the next state so TxD never glitches.
    unique case (tx_state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = tx_sh_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    rx_ferr_d  = rx_ferr_q;
    // Bus clears first so a frame completing in the same cycle takes priority.
    if (rd_data) rx_valid_d = 1'b0;
    if (rd_stat) begin
      rx_ovr_d  = 1'b0;
      rx_ferr_d = 1'b0;
    end
    unique case (rx_state_q)
      S_IDLE: if (!rx_s2_q) begin
        rx_cnt_d   = '0;
        rx_state_d = S_START;
      end
      S_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      S_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      S_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_state_d = S_IDLE;
        if (rx_s2_q) begin
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          if (rx_valid_q && !rd_data) rx_ovr_d = 1'b1;
        end else begin
          rx_ferr_d = 1'b1;
        end
      end else rx_cnt_d = rx_cnt_q + 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[FIFO_AW-1:0]] <= wishbone_data_i[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      rx_s1_q    <= com_RxD;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign wishbone_ack_o  = ack_q;
  assign wishbone_data_o = dat_q;
  assign com_TxD         = txd_q;
  assign tx_state_o      = tx_state_q;
  assign rx_state_o      = rx_state_q;
endmodule

// File: tb/tb_uart_wb_ctrl.sv
// Bench for uart_wb_ctrl: TX bytes are scoreboarded against a serial-line monitor,
// RX frames are driven bit by bit, and register reads are checked against constants.
module tb_uart_wb_ctrl;
  localparam int CPB = 4;
  localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] addr, wdat, rdat;
  logic [3:0]  sel;
  logic        ack, rxd, txd;
  logic [1:0]  tx_st, rx_st;

  int n_chk = 0, n_pass = 0, n_rst = 0;
  logic [7:0] tx_exp [$];

  always #5 clk = ~clk;
  always @(negedge rst_n) n_rst++;

  uart_wb_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_AW(3)) dut (
    .clk(clk), .rst(rst_n),
    .wishbone_cyc_i(cyc), .wishbone_stb_i(stb), .wishbone_we_i(we),
    .wishbone_addr_i(addr), .wishbone_data_i(wdat), .wishbone_select_i(sel),
    .wishbone_data_o(rdat), .wishbone_ack_o(ack),
    .com_RxD(rxd), .com_TxD(txd), .tx_state_o(tx_st), .rx_state_o(rx_st)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r, output int lat);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s;
    r = '0; lat = 0;
    while (lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (ack) break;
    end
    if (ack) r = rdat;
    else chk("bus_ack_timeout", {31'b0, ack}, 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    int lat;
    bus(1'b0, a, 32'h0, 4'hF, r, lat);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    int lat;
    bus(1'b1, a, d, s, r, lat);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Serial monitor: samples mid-bit and checks each frame against the scoreboard.
  initial begin
    logic [7:0] b, e;
    logic st, sp;
    int rc;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        rc = n_rst;
        repeat (CPB / 2) @(negedge clk);
        st = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        sp = txd;
        if (rc == n_rst) begin
          chk("tx_pending", 32'(tx_exp.size() > 0), 32'h1);
          if (tx_exp.size() > 0) begin
            e = tx_exp.pop_front();
            chk("tx_byte", {24'b0, b}, {24'b0, e});
          end
          chk("tx_start", {31'b0, st}, 32'h0);
          chk("tx_stop", {31'b0, sp}, 32'h1);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic [7:0] a5;
    logic exp_b, found;
    int lat, bad;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdat = '0; sel = '0; rxd = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_txd", {31'b0, txd}, 32'h1);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_dat", rdat, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Reset status, single-cycle ack with 1-cycle latency.
    bus(1'b0, A_STAT, 32'h0, 4'hF, r, lat);
    chk("rst_status", r, 32'h2);
    chk("ack_latency", lat, 32'd1);
    @(posedge clk); #1;
    chk("ack_pulse", {31'b0, ack}, 32'h0);
    chk("dat_idle", rdat, 32'h0);

    // Exact waveform of one frame.
    a5 = 8'hA5;
    tx_exp.push_back(a5);
    wr(A_DATA, 32'hA5, 4'h1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    chk("a5_found", {31'b0, found}, 32'h1);
    bad = 0;
    if (found) begin
      for (int k = 0; k < 40; k++) begin
        if (k > 0) @(negedge clk);
        exp_b = (k < 4) ? 1'b0 : (k < 36) ? a5[(k - 4) / 4] : 1'b1;
        if (txd !== exp_b) bad++;
      end
    end
    chk("a5_wave_errs", bad, 32'd0);
    repeat (3) @(posedge clk); #1;
    rd(A_STAT, r);
    chk("a5_status", r, 32'h2);

    // Byte-lane and STATUS writes are acked but have no effect.
    wr(A_DATA, 32'h77, 4'hE);
    wr(A_STAT, 32'hFF, 4'hF);
    rd(A_STAT, r);
    chk("nosel_status", r, 32'h2);

    // Ten back-to-back writes: one to shifter, eight fill FIFO, last dropped.
    for (int i = 0; i < 9; i++) tx_exp.push_back(8'(i));
    for (int i = 0; i < 10; i++) wr(A_DATA, 32'(i), 4'h1);
    rd(A_STAT, r);
    chk("fifo_full_status", r, 32'h1);
    for (int i = 0; i < 1000 && tx_exp.size() != 0; i++) @(posedge clk);
    chk("tx_drain", tx_exp.size(), 32'd0);
    repeat (8) @(posedge clk); #1;
    rd(A_STAT, r);
    chk("drain_status", r, 32'h2);
    repeat (60) @(posedge clk); #1;
    chk("no_extra_tx", {31'b0, txd}, 32'h1);

    // Receive one byte.
    send_rx(8'h3C, 1'b1);
    rd(A_STAT, r);
    chk("rx_status", r, 32'h6);
    rd(A_DATA, r);
    chk("rx_data", r, 32'h3C);
    rd(A_STAT, r);
    chk("rx_status_clr", r, 32'h2);
    rd(A_DATA, r);
    chk("rx_stale", r, 32'h3C);

    // Overrun.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd(A_STAT, r);
    chk("ovr_status", r, 32'hE);
    rd(A_DATA, r);
    chk("ovr_data", r, 32'h22);
    rd(A_STAT, r);
    chk("ovr_clr", r, 32'h2);

    // Framing error.
    send_rx(8'h5A, 1'b0);
    rd(A_STAT, r);
    chk("ferr_status", r, 32'h12);
    rd(A_STAT, r);
    chk("ferr_clr", r, 32'h2);

    // Single-cycle glitch is rejected.
    repeat (10) @(posedge clk); #1;
    rxd = 1'b0;
    @(posedge clk); #1;
    rxd = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("glitch_rx_state", {30'b0, rx_st}, 32'h0);
    rd(A_STAT, r);
    chk("glitch_status", r, 32'h2);

    // Reset mid-frame.
    tx_exp.push_back(8'h55);
    wr(A_DATA, 32'h55, 4'h1);
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_txd", {31'b0, txd}, 32'h1);
    chk("rst_mid_tx_state", {30'b0, tx_st}, 32'h0);
    tx_exp.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rd(A_STAT, r);
    chk("rst_mid_status", r, 32'h2);
    repeat (60) @(posedge clk); #1;
    chk("rst_mid_idle_txd", {31'b0, txd}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
